// File: rtl/sram_pkg.sv
// Shared state type and byte-lane geometry helpers for the sram_bwe_2p family.
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int LANE_W_DEF = 8;

    function automatic int nbe(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

    function automatic int lane_lo(input int k, input int lane_w = LANE_W_DEF);
        return k * lane_w;
    endfunction

    // The top lane runs to the MSB so remainder bits are never orphaned.
    function automatic int lane_hi(input int k, input int n_be, input int data_w,
                                   input int lane_w = LANE_W_DEF);
        return (k == n_be - 1) ? data_w - 1 : k * lane_w + lane_w - 1;
    endfunction

endpackage

// File: rtl/sram_clr_seq.sv
// Post-reset clear sequencer: walks every word once with a zero write, then
// hands the array over to the user ports.
//
// state | meaning
// CLEAR | writing zero to word r_clr_cnt, user ports gated
// READY | clear done, user ports accepted until next reset
module sram_clr_seq
    import sram_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_adr_o,
    output logic              ready_o
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              w_last;

    assign w_last    = (r_clr_cnt == ADDR_W'(DEPTH - 1));
    assign clr_adr_o = r_clr_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLEAR:   if (w_last) w_state_nxt = READY;
            READY:   w_state_nxt = READY;
            default: w_state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        clr_we_o = 1'b0;
        ready_o  = 1'b0;
        case (r_state)
            CLEAR:   clr_we_o = 1'b1;
            READY:   ready_o  = 1'b1;
            default: clr_we_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/sram_bwe_2p.sv
// Simple-dual-port SRAM with byte-lane write enables, registered read and a
// post-reset clear. Define SRAM_BYPASS_EN for write-first collisions (default read-first).
module sram_bwe_2p
    import sram_pkg::*;
#(
    parameter int DATA_W = 41,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512,
    parameter int LANE_W = LANE_W_DEF
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    output logic                             ready_o,
    input  logic [nbe(DATA_W, LANE_W)-1:0]   wen_i,
    input  logic [ADDR_W-1:0]                wadr_i,
    input  logic [DATA_W-1:0]                data_i,
    input  logic                             ren_i,
    input  logic [ADDR_W-1:0]                radr_i,
    output logic [DATA_W-1:0]                data_o,
    output logic                             rvalid_o
);

    localparam int NBE = nbe(DATA_W, LANE_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;

    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_adr;
    logic              w_ready;
    logic [DATA_W-1:0] w_umask;
    logic              w_wadr_ok;
    logic              w_radr_ok;
    logic              w_uwe;
    logic              w_we;
    logic [ADDR_W-1:0] w_adr;
    logic [DATA_W-1:0] w_wmask;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rd_old;
    logic [DATA_W-1:0] w_rd_val;

    sram_clr_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_we_o  (w_clr_we),
        .clr_adr_o (w_clr_adr),
        .ready_o   (w_ready)
    );

    for (genvar k = 0; k < NBE; k++) begin : g_lane
        localparam int LO = lane_lo(k, LANE_W);
        localparam int HI = lane_hi(k, NBE, DATA_W, LANE_W);
        assign w_umask[HI:LO] = {(HI - LO + 1){wen_i[k]}};
    end

    // One extra bit so DEPTH == 2**ADDR_W does not wrap to zero.
    assign w_wadr_ok = ({1'b0, wadr_i} < (ADDR_W + 1)'(DEPTH));
    assign w_radr_ok = ({1'b0, radr_i} < (ADDR_W + 1)'(DEPTH));

    assign w_uwe   = w_ready && w_wadr_ok && (|wen_i);
    assign w_we    = w_clr_we || w_uwe;
    assign w_adr   = w_clr_we ? w_clr_adr : wadr_i;
    assign w_wmask = w_clr_we ? '1 : w_umask;
    assign w_wdata = w_clr_we ? '0 : data_i;

    always_ff @(posedge clk_i) begin
        if (w_we) begin
            r_mem[w_adr] <= (r_mem[w_adr] & ~w_wmask) | (w_wdata & w_wmask);
        end
    end

    assign w_rd_old = w_radr_ok ? r_mem[radr_i] : '0;

`ifdef SRAM_BYPASS_EN
    assign w_rd_val = (w_uwe && (wadr_i == radr_i))
                    ? ((w_rd_old & ~w_umask) | (data_i & w_umask))
                    : w_rd_old;
`else
    assign w_rd_val = w_rd_old;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_ready) begin
            r_rvalid <= ren_i;
            if (ren_i) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    assign ready_o  = w_ready;
    assign rvalid_o = r_rvalid;
    assign data_o   = r_rdata;

endmodule
